fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch front end. Issues one request at a time to the
//            instruction memory, buffers returned words in a 2-entry FIFO of
//            {pc, instr} and presents the head entry to the decode stage.
//            A redirect flushes the FIFO and restarts fetch at redirect_pc. A
//            request that is still in flight when the redirect arrives is
//            completed and its data discarded.
// Ports    : clk          - clock, rising edge
//            rst_n        - synchronous active-low reset
//            imem_req     - instruction memory request
//            imem_addr    - request byte address (held until imem_ack)
//            imem_ack     - memory accepts request / returns data this cycle
//            imem_rdata   - instruction word returned with imem_ack
//            redirect     - restart fetch at redirect_pc
//            redirect_pc  - restart address
//            id_valid     - head instruction valid
//            id_ready     - decode consumes head entry
//            id_instr     - head instruction (NOP when empty)
//            id_opcode    - id_instr[6:0]
//            id_pc        - head instruction address (0 when empty)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [6:0]  id_opcode,
  output logic [31:0] id_pc
);

  localparam logic [31:0] c_NOP   = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [1:0]  c_DEPTH = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;

  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic        w_pop_raw;
  logic        w_push_raw;
  logic        w_push;
  logic        w_pop;
  logic        w_flush;
  logic [1:0]  w_count_after;
  logic [31:0] w_seq_pc;

  assign imem_req  = (state_q == FETCH) || (state_q == DISCARD);
  assign imem_addr = req_addr_q;

  assign id_valid  = (count_q != 2'd0);
  assign id_instr  = id_valid ? fifo_instr_q[rd_ptr_q] : c_NOP;
  assign id_pc     = id_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0000_0000;
  assign id_opcode = id_instr[6:0];

  // Raw push/pop ignore redirect; they only decide whether the FIFO would
  // have room next cycle. The committed push/pop below are masked by flush.
  assign w_pop_raw     = id_valid && id_ready;
  assign w_push_raw    = (state_q == FETCH) && imem_ack;
  assign w_count_after = count_q + {1'b0, w_push_raw} - {1'b0, w_pop_raw};
  assign w_seq_pc      = req_addr_q + 32'd4;

  assign w_flush = redirect;
  assign w_push  = w_push_raw && !w_flush;
  assign w_pop   = w_pop_raw  && !w_flush;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    fetch_pc_d = fetch_pc_q;

    unique case (state_q)
      IDLE: begin
        state_d    = FETCH;
        req_addr_d = fetch_pc_q;
      end
      FETCH: begin
        if (imem_ack) begin
          fetch_pc_d = w_seq_pc;
          if (w_count_after < c_DEPTH) begin
            state_d    = FETCH;
            req_addr_d = w_seq_pc;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (w_count_after < c_DEPTH) begin
          state_d    = FETCH;
          req_addr_d = fetch_pc_q;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          state_d    = FETCH;
          req_addr_d = fetch_pc_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Redirect overrides everything above. An un-acked request must still be
    // completed (address held), so it moves to DISCARD; otherwise the bus is
    // free and fetch restarts immediately at redirect_pc.
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      if (imem_req && !imem_ack) begin
        state_d    = DISCARD;
        req_addr_d = req_addr_q;
      end else begin
        state_d    = FETCH;
        req_addr_d = redirect_pc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointer / occupancy next-state
  // --------------------------------------------------------------------------
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
      if (w_push) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q != 0.
  // A push during reset is suppressed so no stale write lands in the array.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      fifo_pc_q[wr_ptr_q]    <= req_addr_q;
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule
`default_nettype wire
